ex_muldiv: RTL and testbench

- EX-stage iterative multiply/divide unit. Consumes the operand and control fields that the ID/EX pipeline register presents each cycle.
- Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- Supplies HI/LO to MFHI/MFLO and accepts MTHI/MTLO.
- Raises a stall request to the hazard logic while an operation is in flight.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/ex_muldiv.sv | 142 ++++++++++++++
 tb/tb_ex_muldiv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, FSM state type, default width and divide-by-zero constants.
package ex_muldiv_pkg;

    localparam int DW_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // Every LO bit takes this value on divide by zero; HI returns the dividend.
    localparam logic DIV0_LO_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// Multiply acc = {partial product, remaining multiplier}; divide acc = {remainder, dividend/quotient}.
module muldiv_step
    import ex_muldiv_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            is_div,
    input  logic [2*DW-1:0] acc_i,
    input  logic [DW-1:0]   opnd_i,
    output logic [2*DW-1:0] acc_o
);

    logic [DW:0] add_sum;
    logic [DW:0] trial;

    always_comb begin
        add_sum = {1'b0, acc_i[2*DW-1:DW]} + {1'b0, opnd_i};
        // Top bit of trial is the borrow: set means the shifted remainder was smaller.
        trial   = acc_i[2*DW-1:DW-1] - {1'b0, opnd_i};
        acc_o   = acc_i;
        if (is_div) begin
            if (!trial[DW]) begin
                acc_o = {trial[DW-1:0], acc_i[DW-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*DW-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {add_sum, acc_i[DW-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*DW-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on magnitudes for DW cycles, then applies sign correction in FIX.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] rs_dat,
    input  logic [DW-1:0] rt_dat,
    input  logic          hilo_rd,
    input  logic          mthi,
    input  logic          mtlo,
    input  logic          cancel,
    output logic [DW-1:0] hi_out,
    output logic [DW-1:0] lo_out,
    output logic          busy,
    output logic          done,
    output logic          stall_req
);

    localparam int CW = $clog2(DW);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2*DW-1:0] acc_q;
    logic [2*DW-1:0] acc_step;
    logic [DW-1:0]   opnd_q;
    logic [DW-1:0]   hi_q, lo_q;
    logic            isdiv_q, negq_q, negr_q, div0_q;

    logic            accept, commit;
    logic            in_div, in_sgn;
    logic [DW-1:0]   a_mag, b_mag;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo, rem;
    logic [DW-1:0]   fix_hi, fix_lo;

    assign accept = (state_q == IDLE) && start && !cancel;
    assign commit = (state_q == FIX) && !cancel;

    assign in_div = op_is_div(op);
    assign in_sgn = op_is_signed(op);
    assign a_mag  = (in_sgn && rs_dat[DW-1]) ? -rs_dat : rs_dat;
    assign b_mag  = (in_sgn && rt_dat[DW-1]) ? -rt_dat : rt_dat;

    muldiv_step #(
        .DW (DW)
    ) u_step (
        .is_div (isdiv_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Final results are presented combinationally in FIX so HI/LO and done line up.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = commit;
        hi_out    = commit ? fix_hi : hi_q;
        lo_out    = commit ? fix_lo : lo_q;
        stall_req = busy && (start || hilo_rd || mthi || mtlo);
    end

    always_comb begin
        prod_fix = negq_q ? -acc_q : acc_q;
        quo      = acc_q[DW-1:0];
        rem      = acc_q[2*DW-1:DW];
        if (isdiv_q) begin
            fix_hi = negr_q ? -rem : rem;
            fix_lo = div0_q ? {DW{DIV0_LO_BIT}} : (negq_q ? -quo : quo);
        end else begin
            fix_hi = prod_fix[2*DW-1:DW];
            fix_lo = prod_fix[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            isdiv_q <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else if (accept) begin
            isdiv_q <= in_div;
            negq_q  <= in_sgn && (rs_dat[DW-1] ^ rt_dat[DW-1]);
            negr_q  <= in_sgn && rs_dat[DW-1];
            div0_q  <= in_div && (rt_dat == '0);
            opnd_q  <= in_div ? b_mag : a_mag;
            acc_q   <= {{DW{1'b0}}, (in_div ? a_mag : b_mag)};
            cnt_q   <= CW'(DW - 1);
        end else if ((state_q == CALC) && !cancel) begin
            acc_q   <= acc_step;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    // A start in IDLE wins over MTHI/MTLO; MT* while busy is stalled, not executed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if ((state_q == IDLE) && !start) begin
            if (mthi) hi_q <= rs_dat;
            if (mtlo) lo_q <= rs_dat;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, signed/unsigned results, corner divides,
// stall behaviour, cancel and asynchronous reset in flight.
module tb_ex_muldiv;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [DW-1:0] rs_dat = '0;
    logic [DW-1:0] rt_dat = '0;
    logic          hilo_rd = 1'b0;
    logic          mthi = 1'b0;
    logic          mtlo = 1'b0;
    logic          cancel = 1'b0;
    logic [DW-1:0] hi_out, lo_out;
    logic          busy, done, stall_req;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_dat    (rs_dat),
        .rt_dat    (rt_dat),
        .hilo_rd   (hilo_rd),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .cancel    (cancel),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one operation and follows it for 40 cycles; cycle k is the k-th cycle after the start edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int          done_at;
        int          busy_gaps;
        logic        busy34;
        logic [31:0] h, l;
        done_at   = 0;
        busy_gaps = 0;
        busy34    = 1'b1;
        h         = '0;
        l         = '0;
        @(negedge clk);
        start = 1'b1; op = o; rs_dat = a; rt_dat = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done && done_at == 0) begin
                done_at = k;
                h = hi_out;
                l = lo_out;
            end
            if (k <= 33 && !busy) busy_gaps++;
            if (k == 34) busy34 = busy;
        end
        check({tag, "_done_cycle"}, done_at, 33);
        check({tag, "_hi_at_done"}, h, eh);
        check({tag, "_lo_at_done"}, l, el);
        check({tag, "_busy_1_33"}, busy_gaps, 0);
        check({tag, "_busy_34"}, busy34, 1'b0);
        check({tag, "_hi_kept"}, hi_out, eh);
        check({tag, "_lo_kept"}, lo_out, el);
        $display("op %s a=%h b=%h -> hi=%h lo=%h done_at=%0d", tag, a, b, hi_out, lo_out, done_at);
    endtask

    initial begin
        int   bad;
        logic done_seen;

        repeat (2) @(negedge clk);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 2'd3, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_by0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI, then MULTU 6x7 with an MFLO arriving in cycle 5 that must stall until busy drops.
        @(negedge clk);
        mthi = 1'b1; rs_dat = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_write", hi_out, 32'h1234);
        start = 1'b1; op = 2'd1; rs_dat = 32'd6; rt_dat = 32'd7;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 36; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 5) hilo_rd = 1'b1;
            if (k == 35) hilo_rd = 1'b0;
            #1;
            if (stall_req !== ((k >= 5) && (k <= 33))) bad++;
        end
        check("stall_window", bad, 0);
        check("mul67_lo", lo_out, 32'd42);
        check("mul67_hi", hi_out, 32'd0);
        $display("op stall_mfl0 hi=%h lo=%h stall_errs=%0d", hi_out, lo_out, bad);

        // Cancel in cycle 10 of a MULTU: back to IDLE next cycle, HI/LO untouched, no done.
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs_dat = 32'hFFFF_FFFF; rt_dat = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        done_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done) done_seen = 1'b1;
            if (k == 10) begin
                check("cancel_busy_before", busy, 1'b1);
                cancel = 1'b1;
            end
            if (k == 11) begin
                cancel = 1'b0;
                check("cancel_busy_after", busy, 1'b0);
            end
        end
        check("cancel_no_done", done_seen, 1'b0);
        check("cancel_hi", hi_out, 32'd0);
        check("cancel_lo", lo_out, 32'd42);
        $display("op cancel hi=%h lo=%h", hi_out, lo_out);

        // Asynchronous reset in cycle 10 of a MULTU clears everything at once.
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs_dat = 32'h0000_0003; rt_dat = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        hilo_rd = 1'b1;
        reset = 1'b0;
        #1;
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_stall", stall_req, 0);
        $display("op midreset hi=%h lo=%h busy=%b", hi_out, lo_out, busy);
        hilo_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_after_rst", 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
